// File: rtl/sound_pkg.sv
// Types shared by the polyphonic sound path: per-voice waveform selection
// and envelope generator states.
package sound_pkg;

    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        SAW      = 2'd1,
        TRIANGLE = 2'd2,
        OFF      = 2'd3
    } wave_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

endpackage

// File: rtl/sound_voice.sv
// One synthesiser voice: phase accumulator, waveshaper and a linear
// attack/release envelope, all advancing only on enabled sample ticks.
module sound_voice
    import sound_pkg::*;
#(
    parameter int ACC_W        = 24,
    parameter int SAMPLE_W     = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en_i,
    input  logic                tick_i,
    input  logic [ACC_W-1:0]    freq_inc_i,
    input  logic [1:0]          mode_i,
    input  logic                gate_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                active_o
);

    localparam int                  PROD_W    = 2 * SAMPLE_W + 1;
    localparam logic [SAMPLE_W-1:0] LEVEL_MAX = '1;

    logic                step;
    logic [ACC_W-1:0]    phase_q;
    logic [ACC_W-1:0]    phase_d;
    wave_mode_t          mode_q;
    env_state_t          state_q;
    logic [SAMPLE_W-1:0] level_q;
    logic [SAMPLE_W:0]   level_sum;
    logic [SAMPLE_W-1:0] level_up;
    logic [SAMPLE_W-1:0] level_dn;
    logic [SAMPLE_W-1:0] tri_seg;
    logic [SAMPLE_W-1:0] wave;
    logic [PROD_W-1:0]   scaled;

    assign step    = tick_i & en_i;
    assign phase_d = phase_q + freq_inc_i;

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            phase_q <= '0;
            mode_q  <= SQUARE;
        end else if (step) begin
            phase_q <= phase_d;
            mode_q  <= wave_mode_t'(mode_i);
        end
    end

    // Saturating envelope steps; the extra sum bit catches overflow past max.
    assign level_sum = {1'b0, level_q} + (SAMPLE_W+1)'(ATTACK_STEP);
    assign level_up  = level_sum[SAMPLE_W] ? LEVEL_MAX : level_sum[SAMPLE_W-1:0];
    assign level_dn  = (level_q > SAMPLE_W'(RELEASE_STEP))
                     ? level_q - SAMPLE_W'(RELEASE_STEP) : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            level_q <= '0;
        end else if (step) begin
            if (!gate_i) begin
                if (level_q != '0) begin
                    level_q <= level_dn;
                    state_q <= (level_dn == '0) ? IDLE : RELEASE;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE, ATTACK, RELEASE: begin
                        level_q <= level_up;
                        state_q <= (level_up == LEVEL_MAX) ? SUSTAIN : ATTACK;
                    end
                    default: state_q <= SUSTAIN;
                endcase
            end
        end
    end

    assign tri_seg = phase_q[ACC_W-2 -: SAMPLE_W];

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        wave = '0;
        case (mode_q)
            SQUARE:   wave = phase_q[ACC_W-1] ? '1 : '0;
            SAW:      wave = phase_q[ACC_W-1 -: SAMPLE_W];
            TRIANGLE: wave = phase_q[ACC_W-1] ? ~tri_seg : tri_seg;
            default:  wave = '0;
        endcase
    end

    // Scaling by L+1 lets full level pass the wave untouched.
    assign scaled   = PROD_W'(wave) * (PROD_W'(level_q) + PROD_W'(1));
    assign sample_o = SAMPLE_W'(scaled >> SAMPLE_W);
    assign active_o = (state_q != IDLE);

endmodule

// File: rtl/poly_sound_driver.sv
// Polyphonic sound driver: sample-rate divider, NUM_VOICES voices, averaging
// mixer and a registered 1-bit PWM output for the speaker pin.
module poly_sound_driver
    import sound_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int ACC_W        = 24,
    parameter int SAMPLE_W     = 8,
    parameter int SAMPLE_DIV   = 256,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic [NUM_VOICES*ACC_W-1:0] freq_inc,
    input  logic [NUM_VOICES*2-1:0]     mode,
    input  logic [NUM_VOICES-1:0]       gate,
    output logic [SAMPLE_W-1:0]         sample_out,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        pwm_out
);

    localparam int               DIV_W     = $clog2(SAMPLE_DIV);
    localparam int               MIX_SHIFT = $clog2(NUM_VOICES);
    localparam int               SUM_W     = SAMPLE_W + MIX_SHIFT;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0]    div_q;
    logic                tick;
    logic                tick_q;
    logic [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
    logic [NUM_VOICES-1:0] voice_active;
    logic [SUM_W-1:0]    mix_sum;
    logic [SAMPLE_W-1:0] sample_q;
    logic                valid_q;
    logic [SAMPLE_W-1:0] pwm_cnt_q;
    logic [SAMPLE_W-1:0] duty_q;
    logic                pwm_q;

    assign tick = en & (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (!en || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        sound_voice #(
            .ACC_W        (ACC_W),
            .SAMPLE_W     (SAMPLE_W),
            .ATTACK_STEP  (ATTACK_STEP),
            .RELEASE_STEP (RELEASE_STEP)
        ) u_voice (
            .clk        (clk),
            .nrst       (nrst),
            .en_i       (en),
            .tick_i     (tick),
            .freq_inc_i (freq_inc[v*ACC_W +: ACC_W]),
            .mode_i     (mode[v*2 +: 2]),
            .gate_i     (gate[v]),
            .sample_o   (voice_sample[v]),
            .active_o   (voice_active[v])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_sum = mix_sum + SUM_W'(voice_sample[v]);
        end
    end

    // Voice state settles on the tick edge; the mix is captured one clk later.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= tick_q;
            if (tick_q) begin
                sample_q <= SAMPLE_W'(mix_sum >> MIX_SHIFT);
            end
        end
    end

    // Duty reloads only at the period wrap so each PWM period is glitch-free.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
        end else if (!en) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + SAMPLE_W'(1);
            if (pwm_cnt_q == '1) begin
                duty_q <= sample_q;
            end
            pwm_q <= (pwm_cnt_q < duty_q);
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = |voice_active;
    assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_poly_sound_driver.sv
// Self-checking bench for poly_sound_driver: directed envelope/PWM scenarios
// plus randomized segments, all compared every clock against a sample-level model.
module tb_poly_sound_driver;
    import sound_pkg::*;

    localparam int NV    = 4;
    localparam int ACC_W = 24;
    localparam int SW    = 8;
    localparam int DIV   = 16;
    localparam int AS    = 4;
    localparam int RS    = 2;

    logic                   clk      = 1'b0;
    logic                   nrst     = 1'b0;
    logic                   en       = 1'b0;
    logic [NV*ACC_W-1:0]    freq_inc = '0;
    logic [NV*2-1:0]        mode     = '0;
    logic [NV-1:0]          gate     = '0;
    logic [SW-1:0]          sample_out;
    logic                   sample_valid;
    logic                   busy;
    logic                   pwm_out;

    poly_sound_driver #(
        .NUM_VOICES   (NV),
        .ACC_W        (ACC_W),
        .SAMPLE_W     (SW),
        .SAMPLE_DIV   (DIV),
        .ATTACK_STEP  (AS),
        .RELEASE_STEP (RS)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .freq_inc     (freq_inc),
        .mode         (mode),
        .gate         (gate),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: voice phase/level per sample tick, plus output timing.
    int unsigned m_phase [NV];
    int          m_level [NV];
    int          m_mode  [NV];
    env_state_t  m_state [NV];
    int          m_div, m_pwm_cnt, m_duty, m_sample;
    bit          m_valid, m_pwm, m_tick_pend;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0;
            m_level[v] = 0;
            m_mode[v]  = 0;
            m_state[v] = IDLE;
        end
        m_div = 0; m_pwm_cnt = 0; m_duty = 0; m_sample = 0;
        m_valid = 0; m_pwm = 0; m_tick_pend = 0;
    endtask

    function automatic int wave_of(input int unsigned p, input int md);
        int seg;
        bit hi;
        seg = int'((p >> 15) & 255);
        hi  = (p >= 32'h0080_0000);
        case (md)
            0:       return hi ? 255 : 0;
            1:       return int'(p >> 16);
            2:       return hi ? 255 - seg : seg;
            default: return 0;
        endcase
    endfunction

    function automatic int model_mix();
        int s;
        s = 0;
        for (int v = 0; v < NV; v++) begin
            s += wave_of(m_phase[v], m_mode[v]) * (m_level[v] + 1) / 256;
        end
        return s / NV;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = 0;
        for (int v = 0; v < NV; v++) b |= (m_state[v] != IDLE);
        return b;
    endfunction

    task automatic model_tick();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = (m_phase[v] + freq_inc[v*ACC_W +: ACC_W]) & 32'h00FF_FFFF;
            m_mode[v]  = int'(mode[v*2 +: 2]);
            if (gate[v]) begin
                if (m_state[v] != SUSTAIN) begin
                    m_level[v] = (m_level[v] + AS > 255) ? 255 : m_level[v] + AS;
                    m_state[v] = (m_level[v] == 255) ? SUSTAIN : ATTACK;
                end
            end else if (m_level[v] > 0) begin
                m_level[v] = (m_level[v] - RS < 0) ? 0 : m_level[v] - RS;
                m_state[v] = (m_level[v] == 0) ? IDLE : RELEASE;
            end else begin
                m_state[v] = IDLE;
            end
        end
    endtask

    task automatic clk_step();
        int mix;
        bit new_pwm, tick_now;
        @(posedge clk);
        if (!nrst) begin
            model_reset();
        end else begin
            mix     = model_mix();
            new_pwm = en && (m_pwm_cnt < m_duty);
            if (!en) begin
                m_pwm_cnt = 0;
            end else begin
                if (m_pwm_cnt == 255) m_duty = m_sample;
                m_pwm_cnt = (m_pwm_cnt + 1) % 256;
            end
            m_valid = m_tick_pend;
            if (m_tick_pend) m_sample = mix;
            tick_now    = en && (m_div == DIV - 1);
            m_div       = en ? (m_div + 1) % DIV : 0;
            m_tick_pend = tick_now;
            if (tick_now) model_tick();
            m_pwm = new_pwm;
        end
        #1;
        check("sample_out", sample_out, m_sample);
        check("sample_valid", sample_valid, m_valid);
        check("busy", busy, model_busy());
        check("pwm_out", pwm_out, m_pwm);
    endtask

    task automatic run(input int n);
        repeat (n) clk_step();
    endtask

    // Asserts reset between clock edges and checks outputs clear without a clock.
    task automatic do_reset();
        #2 nrst = 1'b0;
        #1;
        model_reset();
        check("rst_sample", sample_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pwm", pwm_out, 0);
        run(2);
        nrst = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        model_reset();
        do_reset();

        // Reset in the middle of a sounding note
        en = 1'b1; mode = '0; gate = 4'b0001;
        freq_inc = '0; freq_inc[0 +: ACC_W] = 24'h80_0000;
        run(5 * DIV + 1);
        check("note_busy", busy, 1);
        do_reset();

        // Attack to sustain on voice 0, square wave toggling every tick
        en = 1'b1; mode = '0; gate = 4'b0001;
        freq_inc = '0; freq_inc[0 +: ACC_W] = 24'h80_0000;
        run(65 * DIV + 1);
        check("attack_peak", sample_out, 63);
        check("attack_busy", busy, 1);
        run(DIV);
        check("attack_low", sample_out, 0);

        // Release: still active after 127 ticks, idle after 128
        gate = 4'b0000;
        run(127 * DIV);
        check("release_127", busy, 1);
        run(DIV);
        check("release_idle", busy, 0);
        check("release_sample", sample_out, 0);

        // Retrigger from release, all voices parked at high phase
        do_reset();
        en = 1'b1; mode = '0; gate = 4'hF;
        for (int v = 0; v < NV; v++) freq_inc[v*ACC_W +: ACC_W] = 24'h80_0000;
        run(DIV + 1);
        freq_inc = '0;
        run(24 * DIV);
        check("retrig_l100", sample_out, 100);
        gate = 4'h0;
        run(10 * DIV);
        check("retrig_l80", sample_out, 80);
        gate = 4'hF;
        run(DIV);
        check("retrig_l84", sample_out, 84);
        run(4); gate = 4'h0; run(5); gate = 4'hF; run(DIV - 9);
        check("short_gate_ignored", sample_out, 88);

        // PWM duty from a steady mid-scale mix
        do_reset();
        en = 1'b1; mode = 8'b0101_0101; gate = 4'hF;
        for (int v = 0; v < NV; v++) freq_inc[v*ACC_W +: ACC_W] = 24'h80_0000;
        run(DIV + 1);
        freq_inc = '0;
        run(63 * DIV);
        check("pwm_sample128", sample_out, 128);
        run(256);
        hi = 0;
        for (int i = 0; i < 256; i++) begin clk_step(); hi += int'(pwm_out); end
        check("pwm_duty128", hi, 128);
        mode = '0;
        hi = 0;
        for (int i = 0; i < 255; i++) begin clk_step(); hi += int'(pwm_out); end
        check("pwm_old_duty", hi, 127);
        hi = 0;
        for (int i = 0; i < 256; i++) begin clk_step(); hi += int'(pwm_out); end
        check("pwm_new_duty", hi, 255);

        // Enable dropped mid-attack while the PWM output is high
        do_reset();
        en = 1'b1; mode = '0; gate = 4'b0001;
        freq_inc = '0; freq_inc[0 +: ACC_W] = 24'h80_0000;
        run(260);
        check("pwm_before_en_low", pwm_out, 1);
        en = 1'b0;
        clk_step();
        check("en_low_pwm", pwm_out, 0);
        run(1000);
        en = 1'b1;
        run(15 * DIV + 1);
        check("resume_attack", sample_out, 31);

        // Randomized segments with occasional resets and enable drops
        for (int s = 0; s < 150; s++) begin
            for (int v = 0; v < NV; v++) begin
                if ($urandom_range(0, 3) == 0) freq_inc[v*ACC_W +: ACC_W] = ACC_W'($urandom);
            end
            if ($urandom_range(0, 2) == 0) mode = NV*2'($urandom);
            if ($urandom_range(0, 7) == 0) gate = NV'($urandom);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 40) == 0) do_reset();
            run($urandom_range(1, 80));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
